// File: rtl/toggle_edge_monitor.sv
// Receive-side checker for a free-running toggle/clock signal.
// Synchronizes tog_in, detects rising edges, counts them, tracks parity, measures the
// rise-to-rise period and flags completion (EDGE_TARGET edges) or a stall (TIMEOUT_CYC).
// Optional macro TOGGLE_EDGE_MONITOR_HIGH_TIME_EN adds high-phase width measurement
// (high_time / high_valid).
module toggle_edge_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned EDGE_TARGET = 21,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tog_in,
  output logic             edge_pulse,
  output logic             parity,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             done,
  output logic             timeout
`ifdef TOGGLE_EDGE_MONITOR_HIGH_TIME_EN
  ,
  output logic [CNT_W-1:0] high_time,
  output logic             high_valid
`endif
);

  localparam logic [CNT_W-1:0] EdgeTarget  = CNT_W'(EDGE_TARGET);
  // Gap value one cycle before expiry; the timeout fires in the update that reaches TIMEOUT_CYC.
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitFirst,
    StMeasure,
    StDone,
    StTimeout
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out;
  logic                   rise;

  state_e           state_q;
  logic             edge_pulse_q;
  logic             parity_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic [CNT_W-1:0] period_q;
  logic             period_valid_q;
  logic             done_q;
  logic             timeout_q;
  logic [CNT_W-1:0] per_cnt_q;
  logic [CNT_W-1:0] gap_q;

  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] per_inc;
  logic [CNT_W-1:0] gap_inc;
  logic             gap_expire;

  // Synchronizer chain plus previous-sample flop; runs in every FSM state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;

  // Counter increments shared by the FSM branches.
  always_comb begin
    cnt_next   = edge_cnt_q + CntOne;
    per_inc    = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + CntOne;
    gap_inc    = gap_q + CntOne;
    gap_expire = (gap_q == TimeoutLast);
  end

  // Monitor FSM with registered outputs; en low always returns to idle and clears results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      edge_pulse_q   <= 1'b0;
      parity_q       <= 1'b0;
      edge_cnt_q     <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      per_cnt_q      <= '0;
      gap_q          <= '0;
    end else begin
      edge_pulse_q   <= 1'b0;
      period_valid_q <= 1'b0;
      if (!en) begin
        state_q    <= StIdle;
        parity_q   <= 1'b0;
        edge_cnt_q <= '0;
        period_q   <= '0;
        done_q     <= 1'b0;
        timeout_q  <= 1'b0;
        per_cnt_q  <= '0;
        gap_q      <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            state_q    <= StWaitFirst;
            edge_cnt_q <= '0;
            per_cnt_q  <= '0;
            gap_q      <= '0;
          end
          StWaitFirst: begin
            if (rise) begin
              edge_pulse_q <= 1'b1;
              edge_cnt_q   <= CntOne;
              parity_q     <= 1'b1;
              per_cnt_q    <= CntOne;
              gap_q        <= '0;
              if (EdgeTarget == CntOne) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q <= StMeasure;
              end
            end else begin
              gap_q <= gap_inc;
              if (gap_expire) begin
                state_q   <= StTimeout;
                timeout_q <= 1'b1;
              end
            end
          end
          StMeasure: begin
            if (rise) begin
              edge_pulse_q   <= 1'b1;
              period_q       <= per_cnt_q;
              period_valid_q <= 1'b1;
              edge_cnt_q     <= cnt_next;
              parity_q       <= ~parity_q;
              per_cnt_q      <= CntOne;
              gap_q          <= '0;
              if (cnt_next == EdgeTarget) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end
            end else begin
              per_cnt_q <= per_inc;
              gap_q     <= gap_inc;
              if (gap_expire) begin
                state_q   <= StTimeout;
                timeout_q <= 1'b1;
              end
            end
          end
          StDone, StTimeout: begin
            // Terminal until en drops: edges ignored, results held.
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign edge_pulse   = edge_pulse_q;
  assign parity       = parity_q;
  assign edge_cnt     = edge_cnt_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign done         = done_q;
  assign timeout      = timeout_q;

`ifdef TOGGLE_EDGE_MONITOR_HIGH_TIME_EN
  logic             fall;
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] high_time_q;
  logic             high_valid_q;

  assign fall = ~sync_out & prev_q;

  // High-phase width: count runs independently of en so a phase is measured in full;
  // it is only reported on a fall seen while measuring.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      high_cnt_q   <= '0;
      high_time_q  <= '0;
      high_valid_q <= 1'b0;
    end else begin
      high_valid_q <= 1'b0;
      if (rise) begin
        high_cnt_q <= CntOne;
      end else if (sync_out && (high_cnt_q != '1)) begin
        high_cnt_q <= high_cnt_q + CntOne;
      end
      if (!en) begin
        high_time_q <= '0;
      end else if ((state_q == StMeasure) && fall) begin
        high_time_q  <= high_cnt_q;
        high_valid_q <= 1'b1;
      end
    end
  end

  assign high_time  = high_time_q;
  assign high_valid = high_valid_q;
`endif

endmodule

// File: tb/tb_toggle_edge_monitor.sv
// Self-checking bench for toggle_edge_monitor: constant vector table, hand-written
// corner sequences and randomized toggling checked against a cycle-time reference model.
module tb_toggle_edge_monitor;

  localparam int unsigned S   = 2;
  localparam int unsigned W   = 16;
  localparam int unsigned TGT = 21;
  localparam int unsigned TO  = 100;
  localparam int          MAXV = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic tog_in = 1'b0;

  logic         edge_pulse, parity, period_valid, done, timeout;
  logic [W-1:0] edge_cnt, period;
  logic         t1_pulse, t1_parity, t1_pv, t1_done, t1_to;
  logic [W-1:0] t1_cnt, t1_period;
`ifdef TOGGLE_EDGE_MONITOR_HIGH_TIME_EN
  logic [W-1:0] high_time, t1_high_time;
  logic         high_valid, t1_high_valid;
`endif

  toggle_edge_monitor #(
    .SYNC_STAGES(S), .CNT_W(W), .EDGE_TARGET(TGT), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tog_in(tog_in),
    .edge_pulse(edge_pulse), .parity(parity), .edge_cnt(edge_cnt), .period(period),
    .period_valid(period_valid), .done(done), .timeout(timeout)
`ifdef TOGGLE_EDGE_MONITOR_HIGH_TIME_EN
    , .high_time(high_time), .high_valid(high_valid)
`endif
  );

  // Boundary instance: the very first edge completes the run.
  toggle_edge_monitor #(
    .SYNC_STAGES(S), .CNT_W(W), .EDGE_TARGET(1), .TIMEOUT_CYC(TO)
  ) dut_t1 (
    .clk(clk), .rst_n(rst_n), .en(en), .tog_in(tog_in),
    .edge_pulse(t1_pulse), .parity(t1_parity), .edge_cnt(t1_cnt), .period(t1_period),
    .period_valid(t1_pv), .done(t1_done), .timeout(t1_to)
`ifdef TOGGLE_EDGE_MONITOR_HIGH_TIME_EN
    , .high_time(t1_high_time), .high_valid(t1_high_valid)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: expected outputs from absolute cycle numbers of events.
  bit h [0:S];  // h[0] = tog_in sampled at the previous edge, h[k] = k edges earlier
  int cyc = 0;
  bit m_idle = 1'b1, m_fin = 1'b0, m_to = 1'b0;
  int last_rise = 0, last_evt = 0, last_hrise = 0;
  bit e_pulse, e_par, e_pv, e_done, e_to, e_hv;
  int e_cnt, e_per, e_ht;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_step();
    bit s_rise, s_fall;
    cyc++;
    s_rise = h[S-1] & ~h[S];
    s_fall = ~h[S-1] & h[S];
    for (int i = S; i > 0; i--) h[i] = h[i-1];
    h[0] = tog_in;
    e_pulse = 1'b0; e_pv = 1'b0; e_hv = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i <= S; i++) h[i] = 1'b0;
      m_idle = 1'b1; m_fin = 1'b0; m_to = 1'b0;
      e_par = 1'b0; e_done = 1'b0; e_to = 1'b0; e_cnt = 0; e_per = 0; e_ht = 0;
    end else begin
      if (s_rise) last_hrise = cyc;
      if (!en) begin
        m_idle = 1'b1; m_fin = 1'b0; m_to = 1'b0;
        e_par = 1'b0; e_done = 1'b0; e_to = 1'b0; e_cnt = 0; e_per = 0; e_ht = 0;
      end else if (m_idle) begin
        m_idle = 1'b0;
        last_evt = cyc;
      end else if (!m_fin && !m_to) begin
        if (s_fall && e_cnt >= 1) begin
          e_ht = sat(cyc - last_hrise);
          e_hv = 1'b1;
        end
        if (s_rise) begin
          e_cnt++;
          e_pulse = 1'b1;
          e_par = e_cnt[0];
          if (e_cnt >= 2) begin
            e_per = sat(cyc - last_rise);
            e_pv = 1'b1;
          end
          last_rise = cyc;
          last_evt = cyc;
          if (e_cnt == TGT) begin
            m_fin = 1'b1;
            e_done = 1'b1;
          end
        end else if (cyc - last_evt >= TO) begin
          m_to = 1'b1;
          e_to = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [63:0] act_vec();
`ifdef TOGGLE_EDGE_MONITOR_HIGH_TIME_EN
    return 64'({edge_pulse, parity, edge_cnt, period, period_valid, done, timeout,
                high_time, high_valid});
`else
    return 64'({edge_pulse, parity, edge_cnt, period, period_valid, done, timeout});
`endif
  endfunction

  function automatic logic [63:0] exp_vec();
`ifdef TOGGLE_EDGE_MONITOR_HIGH_TIME_EN
    return 64'({e_pulse, e_par, W'(e_cnt), W'(e_per), e_pv, e_done, e_to, W'(e_ht), e_hv});
`else
    return 64'({e_pulse, e_par, W'(e_cnt), W'(e_per), e_pv, e_done, e_to});
`endif
  endfunction

  // Per-cycle bookkeeping observed by the sequences.
  int tick_no = 0;
  int pulses = 0;
  int last_pulse_tick = 0;
  int cap_cnt = 0;
  bit cap_pv = 1'b0;
  bit chk_steady = 1'b0;
  int hv_seen = 0;

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    tick_no++;
    check("model", act_vec(), exp_vec());
    if (edge_pulse) begin
      pulses++;
      last_pulse_tick = tick_no;
      cap_cnt = int'(edge_cnt);
      cap_pv = period_valid;
      if (chk_steady && pulses >= 2)
        check("steady period/parity", {period_valid, period, parity},
              {1'b1, 16'd20, pulses[0]});
    end
`ifdef TOGGLE_EDGE_MONITOR_HIGH_TIME_EN
    if (high_valid) hv_seen++;
`endif
  endtask

  task automatic hold(input bit v, input int n);
    tog_in = v;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; tog_in = 1'b0;
    tick();
    rst_n = 1'b1;
    pulses = 0;
    hv_seen = 0;
  endtask

  typedef struct {
    bit rst_n, en, tog;
    bit pulse, par, pv, done;
    int cnt, per;
    bit t1_pulse, t1_done;
    int t1_cnt;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst en tog | pulse par pv done cnt per | t1: pulse done cnt
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // first high sample
    tbl[3]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 1, 1, 1, 0, 0, 1, 0, 1, 1, 1};  // first edge, no period
    tbl[5]  = '{1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 1};
    tbl[6]  = '{1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1};
    tbl[7]  = '{1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1};
    tbl[8]  = '{1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 1};
    tbl[9]  = '{1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 1};
    tbl[10] = '{1, 1, 1, 1, 0, 1, 0, 2, 6, 0, 1, 1};  // second edge, period 6
    tbl[11] = '{1, 1, 1, 0, 0, 0, 0, 2, 6, 0, 1, 1};
    tbl[12] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // en low clears
    tbl[13] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // steady high: no new edge

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; tog_in = tbl[i].tog;
      tick();
      check($sformatf("table row %0d", i),
            {edge_pulse, parity, period_valid, done, edge_cnt, period,
             t1_pulse, t1_done, t1_cnt},
            {tbl[i].pulse, tbl[i].par, tbl[i].pv, tbl[i].done, W'(tbl[i].cnt),
             W'(tbl[i].per), tbl[i].t1_pulse, tbl[i].t1_done, W'(tbl[i].t1_cnt)});
    end

    // Steady 20-cycle toggling through completion and beyond.
    do_reset();
    en = 1'b1;
    tick();
    chk_steady = 1'b1;
    for (int k = 0; k < 23; k++) begin
      hold(1'b1, 10);
      hold(1'b0, 10);
    end
    chk_steady = 1'b0;
    check("done after target", {done, edge_cnt, period}, {1'b1, 16'd21, 16'd20});
    check("pulses up to target only", 64'(pulses), 64'd21);
    check("target=1 instance", {t1_done, t1_cnt, t1_pv}, {1'b1, 16'd1, 1'b0});

    // Stall after three edges.
    do_reset();
    en = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      hold(1'b1, 10);
      hold(1'b0, 10);
    end
    for (int k = 0; k < 200 && !timeout; k++) tick();
    check("timeout distance", 64'(tick_no - last_pulse_tick), 64'(TO));
    check("timeout count", {timeout, edge_cnt}, {1'b1, 16'd3});
    en = 1'b0;
    tick();
    en = 1'b1;
    check("en low clears timeout", {timeout, edge_cnt}, {1'b0, 16'd0});

    // Reset in the middle of a run.
    do_reset();
    en = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      hold(1'b1, 10);
      hold(1'b0, 10);
    end
    check("five edges before reset", 64'(pulses), 64'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("reset clears outputs", act_vec(), 64'd0);
    cap_cnt = 0;
    cap_pv = 1'b1;
    tick();
    hold(1'b1, 10);
    check("first edge after re-arm", {16'(cap_cnt), cap_pv}, {16'd1, 1'b0});
    hold(1'b0, 10);

`ifdef TOGGLE_EDGE_MONITOR_HIGH_TIME_EN
    do_reset();
    en = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      hold(1'b1, 8);
      hold(1'b0, 12);
    end
    check("high phases", {high_time, period, 16'(hv_seen)}, {16'd8, 16'd20, 16'd6});
`endif

    // Randomized toggling with occasional disables, resets and long stalls.
    do_reset();
    en = 1'b1;
    for (int it = 0; it < 160; it++) begin
      int r, len;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else if (r < 9) begin
        en = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        en = 1'b1;
      end
      len = (r >= 93) ? int'($urandom_range(90, 130)) : int'($urandom_range(1, 25));
      hold(~tog_in, len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
